dcache_wb: RTL

Parametrised, write-back, write-allocate data cache with its own miss controller. It sits between the beta datapath (ALU result as address, register B as store data) and the external memory handshake. It supports direct-mapped or 2-way set-associative organisation and a configurable set count. Dirty victims are written back before refill, and the CPU is stalled for the whole miss sequence.

---
 rtl/dcache_wb.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/dcache_wb.sv
// Write-back, write-allocate data cache (direct-mapped or 2-way) with an
// IDLE/WB/FILL miss controller that stalls the CPU until the retry cycle hits.
module dcache_wb #(
   parameter int SETS = 16,
   parameter int WAYS = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cpu_read,
   input  logic        cpu_write,
   input  logic [31:0] cpu_addr,
   input  logic [31:0] cpu_wdata,
   output logic [31:0] cpu_rdata,
   output logic        hit,
   output logic        stall,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   output logic        mem_read,
   input  logic        mem_read_ready,
   output logic        mem_write,
   input  logic        mem_write_done
);
   localparam int IDX = $clog2(SETS);
   localparam int TW  = 30 - IDX;

   // Handshake: each strobe is held with stable mem_addr/mem_wdata until the
   // cycle its ready/done is sampled high, and drops on the following edge.
   typedef enum logic [1:0] {S_IDLE, S_WB, S_FILL} state_t;

   state_t                 state_q, state_d;
   logic [1:0][SETS-1:0]   valid_q, valid_d, dirty_q, dirty_d;
   logic [SETS-1:0]        lru_q, lru_d;
   logic [TW-1:0]          tag_q  [2][SETS];
   logic [TW-1:0]          tag_d  [2][SETS];
   logic [31:0]            data_q [2][SETS];
   logic [31:0]            data_d [2][SETS];
   logic                   op_q, op_d, way_q, way_d;
   logic [31:0]            addr_q, addr_d, wdata_q, wdata_d;
   logic                   mem_read_q, mem_read_d, mem_write_q, mem_write_d;
   logic [31:0]            mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;

   logic                   req, m0, m1, any_hit, hw, vic;
   logic [IDX-1:0]         idx, lidx;
   logic [TW-1:0]          tag, ltag;
   logic                   unused_addr_bits;

   assign unused_addr_bits = ^{cpu_addr[1:0], addr_q[1:0]};

   assign req     = cpu_read | cpu_write;
   assign idx     = cpu_addr[IDX+1:2];
   assign tag     = cpu_addr[31:IDX+2];
   assign lidx    = addr_q[IDX+1:2];
   assign ltag    = addr_q[31:IDX+2];
   assign m0      = valid_q[0][idx] && (tag_q[0][idx] == tag);
   assign m1      = (WAYS == 2) && valid_q[1][idx] && (tag_q[1][idx] == tag);
   assign any_hit = m0 | m1;
   assign hw      = m1;
   assign hit     = (state_q == S_IDLE) && req && any_hit;
   assign stall   = (state_q != S_IDLE) || (req && !any_hit);
   assign cpu_rdata = hit ? data_q[hw][idx] : 32'd0;

   // Invalid ways are filled first (way 0 preferred), then LRU picks.
   assign vic = (WAYS == 1)        ? 1'b0 :
                !valid_q[0][idx]   ? 1'b0 :
                !valid_q[1][idx]   ? 1'b1 : lru_q[idx];

   assign mem_read  = mem_read_q;
   assign mem_write = mem_write_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;

   always_comb begin
      state_d     = state_q;
      valid_d     = valid_q;
      dirty_d     = dirty_q;
      lru_d       = lru_q;
      tag_d       = tag_q;
      data_d      = data_q;
      op_d        = op_q;
      way_d       = way_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      mem_read_d  = mem_read_q;
      mem_write_d = mem_write_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      case (state_q)
         S_IDLE: begin
            if (hit) begin
               if (cpu_write) begin
                  data_d[hw][idx]  = cpu_wdata;
                  dirty_d[hw][idx] = 1'b1;
               end
               if (WAYS == 2) lru_d[idx] = ~hw;
            end else if (req) begin
               op_d    = cpu_write;
               addr_d  = cpu_addr;
               wdata_d = cpu_wdata;
               way_d   = vic;
               if (valid_q[vic][idx] && dirty_q[vic][idx]) begin
                  state_d     = S_WB;
                  mem_write_d = 1'b1;
                  mem_addr_d  = {tag_q[vic][idx], idx, 2'b00};
                  mem_wdata_d = data_q[vic][idx];
               end else begin
                  state_d    = S_FILL;
                  mem_read_d = 1'b1;
                  mem_addr_d = {cpu_addr[31:2], 2'b00};
               end
            end
         end
         S_WB: begin
            if (mem_write_done) begin
               dirty_d[way_q][lidx] = 1'b0;
               state_d     = S_FILL;
               mem_write_d = 1'b0;
               mem_read_d  = 1'b1;
               mem_addr_d  = {addr_q[31:2], 2'b00};
            end
         end
         S_FILL: begin
            if (mem_read_ready) begin
               valid_d[way_q][lidx] = 1'b1;
               dirty_d[way_q][lidx] = op_q;
               tag_d[way_q][lidx]   = ltag;
               data_d[way_q][lidx]  = op_q ? wdata_q : mem_rdata;
               if (WAYS == 2) lru_d[lidx] = ~way_q;
               mem_read_d = 1'b0;
               state_d    = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         valid_q     <= '0;
         dirty_q     <= '0;
         lru_q       <= '0;
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         state_q     <= state_d;
         valid_q     <= valid_d;
         dirty_q     <= dirty_d;
         lru_q       <= lru_d;
         mem_read_q  <= mem_read_d;
         mem_write_q <= mem_write_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
      end
   end

   // Line payload and the latched request carry no reset value.
   always_ff @(posedge clk) begin
      tag_q   <= tag_d;
      data_q  <= data_d;
      op_q    <= op_d;
      way_q   <= way_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
   end
endmodule
